fp21_min_reduce: RTL and testbench

FP21_MIN_REDUCE -- requirements
Module: fp21_min_reduce

---
 rtl/fp21_min_reduce.sv | 132 +++++++++++++
 tb/tb_fp21_min_reduce.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp21_min_reduce.sv
// Streaming minimum reduction over groups of FP21 candidates. Each group
// yields the smallest hit (earliest wins ties), its tag, and the beat count.
module fp21_min_reduce #(
    parameter int EXP_W  = 7,
    parameter int FRAC_W = 14,
    parameter int ID_W   = 16,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic                    s_hit,
    input  logic                    s_sign,
    input  logic signed [EXP_W-1:0] s_exp,
    input  logic [FRAC_W-1:0]       s_frac,
    input  logic [ID_W-1:0]         s_id,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_hit,
    output logic                    m_sign,
    output logic [EXP_W-1:0]        m_exp,
    output logic [FRAC_W-1:0]       m_frac,
    output logic [ID_W-1:0]         m_id,
    output logic [CNT_W-1:0]        m_count
);

    typedef enum logic [1:0] {EMPTY, ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                    state_q, state_d;
    logic                      hit_q, hit_d;
    logic                      sign_q, sign_d;
    logic signed [EXP_W-1:0]   exp_q, exp_d;
    logic [FRAC_W-1:0]         frac_q, frac_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      cand_lt;

    // Strict a < b. Same-sign negatives order by descending magnitude, so the
    // magnitude test flips to strict greater-than to keep ties non-replacing.
    function automatic logic fp_lt(
        input logic                    a_s,
        input logic signed [EXP_W-1:0] a_e,
        input logic [FRAC_W-1:0]       a_f,
        input logic                    b_s,
        input logic signed [EXP_W-1:0] b_e,
        input logic [FRAC_W-1:0]       b_f
    );
        logic mag_lt, mag_gt;
        mag_lt = (a_e < b_e) || ((a_e == b_e) && (a_f < b_f));
        mag_gt = (a_e > b_e) || ((a_e == b_e) && (a_f > b_f));
        if (a_s != b_s) return a_s;
        return a_s ? mag_gt : mag_lt;
    endfunction

    assign cand_lt = fp_lt(s_sign, s_exp, s_frac, sign_q, exp_q, frac_q);

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        id_d    = id_q;
        count_d = count_q;
        s_ready = (state_q != DONE);
        m_valid = (state_q == DONE);
        case (state_q)
            EMPTY: begin
                if (s_valid) begin
                    hit_d   = s_hit;
                    sign_d  = s_sign;
                    exp_d   = s_exp;
                    frac_d  = s_frac;
                    id_d    = s_id;
                    count_d = CNT_W'(1);
                    state_d = s_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (s_valid) begin
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
                    if (s_hit && (!hit_q || cand_lt)) begin
                        hit_d  = 1'b1;
                        sign_d = s_sign;
                        exp_d  = s_exp;
                        frac_d = s_frac;
                        id_d   = s_id;
                    end
                    if (s_last) state_d = DONE;
                end
            end
            DONE: begin
                if (m_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            hit_q   <= 1'b0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            frac_q  <= '0;
            id_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
            id_q    <= id_d;
            count_q <= count_d;
        end
    end

    // The running-min registers double as the registered result; they only
    // change on accepted beats, so they hold steady throughout DONE.
    assign m_hit   = hit_q;
    assign m_sign  = sign_q;
    assign m_exp   = exp_q;
    assign m_frac  = frac_q;
    assign m_id    = id_q;
    assign m_count = count_q;

endmodule

// File: tb/tb_fp21_min_reduce.sv
// Randomized and directed bench for fp21_min_reduce against a real-valued
// reference model of group minimum selection.
module tb_fp21_min_reduce;

    localparam int EXP_W  = 7;
    localparam int FRAC_W = 14;
    localparam int ID_W   = 16;
    localparam int CNT_W  = 4;
    localparam int RW     = 2 + EXP_W + FRAC_W + ID_W + CNT_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct {
        logic              hit;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic [ID_W-1:0]   id;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    s_valid, s_ready, s_last, s_hit, s_sign;
    logic signed [EXP_W-1:0] s_exp;
    logic [FRAC_W-1:0]       s_frac;
    logic [ID_W-1:0]         s_id;
    logic                    m_valid, m_ready, m_hit, m_sign;
    logic [EXP_W-1:0]        m_exp;
    logic [FRAC_W-1:0]       m_frac;
    logic [ID_W-1:0]         m_id;
    logic [CNT_W-1:0]        m_count;

    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t grp[$];

    fp21_min_reduce #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_hit(s_hit),
        .s_sign(s_sign), .s_exp(s_exp), .s_frac(s_frac), .s_id(s_id),
        .m_valid(m_valid), .m_ready(m_ready), .m_hit(m_hit), .m_sign(m_sign),
        .m_exp(m_exp), .m_frac(m_frac), .m_id(m_id), .m_count(m_count)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(bit hit, bit sign, int e, int f, int id);
        beat_t b;
        b.hit  = hit;
        b.sign = sign;
        b.exp  = EXP_W'(e);
        b.frac = FRAC_W'(f);
        b.id   = ID_W'(id);
        return b;
    endfunction

    // Numeric value (-1)^s * (1 + frac/2^FRAC_W) * 2^exp; exact in a double.
    function automatic real fpval(beat_t b);
        real m;
        int  e;
        m = 1.0 + real'(b.frac) / real'(1 << FRAC_W);
        e = $signed(b.exp);
        for (int i = 0; i < e; i++) m = m * 2.0;
        for (int i = 0; i > e; i--) m = m / 2.0;
        return b.sign ? -m : m;
    endfunction

    function automatic logic [RW-1:0] expect_vec();
        beat_t best;
        bit    have;
        int    cnt;
        best = grp[0];
        have = grp[0].hit;
        for (int i = 1; i < grp.size(); i++)
            if (grp[i].hit && (!have || fpval(grp[i]) < fpval(best))) begin
                best = grp[i];
                have = 1'b1;
            end
        cnt = (grp.size() > CMAX) ? CMAX : grp.size();
        return {have, best.sign, best.exp, best.frac, best.id, CNT_W'(cnt)};
    endfunction

    function automatic logic [RW-1:0] obs_vec();
        return {m_hit, m_sign, m_exp, m_frac, m_id, m_count};
    endfunction

    task automatic drive_group(input bit with_last);
        for (int i = 0; i < grp.size(); i++) begin
            s_valid = 1'b1;
            s_last  = with_last && (i == grp.size() - 1);
            s_hit   = grp[i].hit;
            s_sign  = grp[i].sign;
            s_exp   = grp[i].exp;
            s_frac  = grp[i].frac;
            s_id    = grp[i].id;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release_out();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++;
        if (m_valid !== 1'b0 || obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b %h expected v=0 0", m_valid, obs_vec());
        end
        #9 rst_n = 1'b1;
        #1;
        n_chk++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_s_ready: got %b expected 1", s_ready);
        end
    endtask

    task automatic test_directed();
        string name;
        logic [RW-1:0] expv;
        for (int sc = 0; sc < 7; sc++) begin
            grp.delete();
            case (sc)
                0: begin
                    name = "three_hits";
                    grp.push_back(mk(1, 0, 2, 8192, 5));
                    grp.push_back(mk(1, 0, 1, 4096, 6));
                    grp.push_back(mk(1, 0, 1, 12288, 7));
                end
                1: begin
                    name = "mixed_sign";
                    grp.push_back(mk(1, 0, 0, 0, 1));
                    grp.push_back(mk(1, 1, -3, 0, 2));
                end
                2: begin
                    name = "both_negative";
                    grp.push_back(mk(1, 1, 2, 0, 10));
                    grp.push_back(mk(1, 1, 5, 0, 11));
                end
                3: begin
                    name = "tie_keeps_first";
                    grp.push_back(mk(1, 0, 3, 100, 9));
                    grp.push_back(mk(1, 0, 3, 100, 4));
                end
                4: begin
                    name = "neg_zero";
                    grp.push_back(mk(1, 1, -64, 0, 3));
                    grp.push_back(mk(1, 0, -64, 0, 8));
                end
                5: begin
                    name = "all_miss";
                    grp.push_back(mk(0, 0, 4, 77, 12));
                    grp.push_back(mk(0, 1, 9, 5, 13));
                    grp.push_back(mk(0, 1, -2, 1, 14));
                    grp.push_back(mk(0, 0, -9, 3, 15));
                end
                default: begin
                    name = "miss_then_hit";
                    grp.push_back(mk(0, 1, 0, 0, 20));
                    grp.push_back(mk(1, 0, 20, 9, 21));
                end
            endcase
            expv = expect_vec();
            drive_group(1'b1);
            @(negedge clk);
            n_chk++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || obs_vec() !== expv) begin
                n_fail++;
                $display("FAIL %s: got v=%b r=%b %h expected v=1 r=0 %h",
                         name, m_valid, s_ready, obs_vec(), expv);
            end
            @(posedge clk);
            #1;
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] expv;
        grp.delete();
        grp.push_back(mk(1, 0, 1, 50, 30));
        grp.push_back(mk(1, 0, 1, 40, 31));
        grp.push_back(mk(1, 0, 1, 60, 32));
        expv = expect_vec();
        drive_group(1'b1);
        // Offer an extra beat during DONE; it must not be taken until EMPTY.
        s_valid = 1'b1; s_last = 1'b1; s_hit = 1'b1; s_sign = 1'b1;
        s_exp = 7'sd3; s_frac = 14'd7; s_id = 16'd99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_chk++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || obs_vec() !== expv) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got v=%b r=%b %h expected v=1 r=0 %h",
                         c, m_valid, s_ready, obs_vec(), expv);
            end
        end
        @(posedge clk);
        #1;
        release_out();
        @(negedge clk);
        n_chk++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_to_empty: got v=%b r=%b expected v=0 r=1", m_valid, s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        grp.delete();
        grp.push_back(mk(1, 1, 3, 7, 99));
        expv = expect_vec();
        @(negedge clk);
        n_chk++;
        if (m_valid !== 1'b1 || obs_vec() !== expv) begin
            n_fail++;
            $display("FAIL no_accept_on_release: got v=%b %h expected v=1 %h",
                     m_valid, obs_vec(), expv);
        end
        @(posedge clk);
        #1;
        release_out();
    endtask

    task automatic test_saturate();
        logic [RW-1:0] expv;
        grp.delete();
        for (int i = 0; i < CMAX + 5; i++)
            grp.push_back(mk(1, 0, 5, 1000 - i * 10, 100 + i));
        expv = expect_vec();
        drive_group(1'b1);
        @(negedge clk);
        n_chk++;
        if (m_valid !== 1'b1 || obs_vec() !== expv) begin
            n_fail++;
            $display("FAIL count_saturate: got v=%b %h expected v=1 %h", m_valid, obs_vec(), expv);
        end
        @(posedge clk);
        #1;
        release_out();
    endtask

    task automatic test_reset_mid();
        logic [RW-1:0] expv;
        grp.delete();
        grp.push_back(mk(1, 0, 1, 1, 40));
        grp.push_back(mk(1, 0, 0, 1, 41));
        drive_group(1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (m_valid !== 1'b0 || obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_group: got v=%b %h expected v=0 0", m_valid, obs_vec());
        end
        #2 rst_n = 1'b1;
        grp.delete();
        grp.push_back(mk(1, 1, -5, 300, 50));
        expv = expect_vec();
        drive_group(1'b1);
        @(negedge clk);
        n_chk++;
        if (m_valid !== 1'b1 || obs_vec() !== expv) begin
            n_fail++;
            $display("FAIL first_edge_accept: got v=%b %h expected v=1 %h", m_valid, obs_vec(), expv);
        end
        // Reset while the result is pending must drop it.
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_done: got v=%b expected v=0", m_valid);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [RW-1:0] expv;
        int len;
        for (int g = 0; g < 40; g++) begin
            grp.delete();
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0)
                    grp.push_back(mk($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                                     $urandom_range(0, 127) - 64, $urandom_range(0, 16383),
                                     $urandom_range(0, 65535)));
                else
                    grp.push_back(mk($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                                     $urandom_range(0, 4) - 2, $urandom_range(0, 2) * 4096,
                                     $urandom_range(0, 65535)));
            end
            expv = expect_vec();
            drive_group(1'b1);
            @(negedge clk);
            n_chk++;
            if (m_valid !== 1'b1 || obs_vec() !== expv) begin
                n_fail++;
                $display("FAIL random_group%0d: got v=%b %h expected v=1 %h",
                         g, m_valid, obs_vec(), expv);
            end
            @(posedge clk);
            #1;
            release_out();
        end
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_hit = 1'b0; s_sign = 1'b0;
        s_exp = '0; s_frac = '0; s_id = '0; m_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
